// File: rtl/rename_map_table.sv
// Register alias table for the rename stage.
//
// Maps RN_WIDTH architectural register indices per cycle to physical tags and
// tracks a ready bit for every physical register. Lane 0 is the oldest lane.
// The table can snapshot the map on a branch and restore it in one cycle on a
// mispredict.
//
// Ports
//   clk, rst                    clock; synchronous active-low reset
//   rn_valid                    lane valid
//   rn_rs1_idx / rn_rs2_idx     source architectural indices, packed per lane
//   rn_rd_idx                   destination architectural index, packed per lane
//   rn_rd_write                 lane allocates a new tag for rd
//   rn_rd_tag                   new physical tag from the free list, packed per lane
//   rs1_tag / rs2_tag           source physical tags (combinational)
//   rs1_ready / rs2_ready       source operand ready (combinational)
//   rd_old_tag                  previous mapping of rd, freed later by the ROB
//   wb_valid / wb_tag           writeback wakeup broadcast
//   ckpt_save                   snapshot the map including this cycle's renames
//   ckpt_id / ckpt_full         slot the next save takes / no slot free (registered)
//   ckpt_restore                restore the map from ckpt_restore_id
//   ckpt_restore_id             slot to restore
//   ckpt_kill_mask              slots freed on restore
//   ckpt_release                free slot ckpt_release_id (branch resolved correct)
//   ckpt_release_id             slot to free
module rename_map_table #(
  parameter int unsigned RN_WIDTH   = 2,
  parameter int unsigned AREG_WIDTH = 5,
  parameter int unsigned NUM_AREG   = 32,
  parameter int unsigned PREG_WIDTH = 6,
  parameter int unsigned NUM_PREG   = 64,
  parameter int unsigned NUM_WB     = 2,
  parameter int unsigned NUM_CKPT   = 4,
  parameter int unsigned CKPT_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RN_WIDTH-1:0]            rn_valid,
  input  logic [RN_WIDTH*AREG_WIDTH-1:0] rn_rs1_idx,
  input  logic [RN_WIDTH*AREG_WIDTH-1:0] rn_rs2_idx,
  input  logic [RN_WIDTH*AREG_WIDTH-1:0] rn_rd_idx,
  input  logic [RN_WIDTH-1:0]            rn_rd_write,
  input  logic [RN_WIDTH*PREG_WIDTH-1:0] rn_rd_tag,
  output logic [RN_WIDTH*PREG_WIDTH-1:0] rs1_tag,
  output logic [RN_WIDTH*PREG_WIDTH-1:0] rs2_tag,
  output logic [RN_WIDTH-1:0]            rs1_ready,
  output logic [RN_WIDTH-1:0]            rs2_ready,
  output logic [RN_WIDTH*PREG_WIDTH-1:0] rd_old_tag,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB*PREG_WIDTH-1:0]   wb_tag,
  input  logic                           ckpt_save,
  output logic [CKPT_WIDTH-1:0]          ckpt_id,
  output logic                           ckpt_full,
  input  logic                           ckpt_restore,
  input  logic [CKPT_WIDTH-1:0]          ckpt_restore_id,
  input  logic [NUM_CKPT-1:0]            ckpt_kill_mask,
  input  logic                           ckpt_release,
  input  logic [CKPT_WIDTH-1:0]          ckpt_release_id
);

  typedef logic [NUM_AREG-1:0][PREG_WIDTH-1:0] map_t;

  map_t                  map_q, map_d, map_ren;
  map_t                  ckpt_q [NUM_CKPT];
  logic [NUM_PREG-1:0]   ready_q, ready_d;
  logic [NUM_CKPT-1:0]   busy_q, busy_d;
  logic [CKPT_WIDTH-1:0] ckpt_id_q, ckpt_id_d;
  logic                  ckpt_full_q, ckpt_full_d;
  logic                  save_en;

  // Per-lane unpacked views of the packed ports.
  logic [AREG_WIDTH-1:0] rs1_idx_l [RN_WIDTH];
  logic [AREG_WIDTH-1:0] rs2_idx_l [RN_WIDTH];
  logic [AREG_WIDTH-1:0] rd_idx_l  [RN_WIDTH];
  logic [PREG_WIDTH-1:0] new_tag_l [RN_WIDTH];
  logic [PREG_WIDTH-1:0] wb_tag_l  [NUM_WB];
  logic [RN_WIDTH-1:0]   lane_wr;

  logic [PREG_WIDTH-1:0] s1_tag [RN_WIDTH];
  logic [PREG_WIDTH-1:0] s2_tag [RN_WIDTH];
  logic [PREG_WIDTH-1:0] old_tag [RN_WIDTH];
  logic [RN_WIDTH-1:0]   s1_byp, s2_byp, s1_rdy, s2_rdy;

  for (genvar g = 0; g < RN_WIDTH; g++) begin : g_lane
    assign rs1_idx_l[g] = rn_rs1_idx[g*AREG_WIDTH +: AREG_WIDTH];
    assign rs2_idx_l[g] = rn_rs2_idx[g*AREG_WIDTH +: AREG_WIDTH];
    assign rd_idx_l[g]  = rn_rd_idx[g*AREG_WIDTH +: AREG_WIDTH];
    assign new_tag_l[g] = rn_rd_tag[g*PREG_WIDTH +: PREG_WIDTH];
    // x0 is hardwired: a write to it never allocates.
    assign lane_wr[g]   = rn_valid[g] & rn_rd_write[g] & (rd_idx_l[g] != '0);

    assign rs1_tag[g*PREG_WIDTH +: PREG_WIDTH]    = s1_tag[g];
    assign rs2_tag[g*PREG_WIDTH +: PREG_WIDTH]    = s2_tag[g];
    assign rd_old_tag[g*PREG_WIDTH +: PREG_WIDTH] = old_tag[g];
    assign rs1_ready[g] = s1_rdy[g];
    assign rs2_ready[g] = s2_rdy[g];
  end

  for (genvar w = 0; w < NUM_WB; w++) begin : g_wb
    assign wb_tag_l[w] = wb_tag[w*PREG_WIDTH +: PREG_WIDTH];
  end

  // Same-cycle wakeup: a tag being written back this cycle counts as ready.
  function automatic logic wb_hit(input logic [NUM_WB-1:0]            v,
                                  input logic [NUM_WB*PREG_WIDTH-1:0] t,
                                  input logic [PREG_WIDTH-1:0]        tag);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < int'(NUM_WB); w++) begin
      if (v[w] && (t[w*PREG_WIDTH +: PREG_WIDTH] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Lookups with intra-group bypass. Iterating older lanes in ascending order
  // leaves the youngest matching older lane as the winner.
  always_comb begin
    for (int j = 0; j < int'(RN_WIDTH); j++) begin
      s1_tag[j]  = map_q[rs1_idx_l[j]];
      s2_tag[j]  = map_q[rs2_idx_l[j]];
      old_tag[j] = map_q[rd_idx_l[j]];
      s1_byp[j]  = 1'b0;
      s2_byp[j]  = 1'b0;
      for (int k = 0; k < j; k++) begin
        if (lane_wr[k] && (rd_idx_l[k] == rs1_idx_l[j])) begin
          s1_tag[j] = new_tag_l[k];
          s1_byp[j] = 1'b1;
        end
        if (lane_wr[k] && (rd_idx_l[k] == rs2_idx_l[j])) begin
          s2_tag[j] = new_tag_l[k];
          s2_byp[j] = 1'b1;
        end
        if (lane_wr[k] && (rd_idx_l[k] == rd_idx_l[j])) begin
          old_tag[j] = new_tag_l[k];
        end
      end
      if (rs1_idx_l[j] == '0) begin
        s1_rdy[j] = 1'b1;
      end else if (s1_byp[j]) begin
        s1_rdy[j] = 1'b0;
      end else begin
        s1_rdy[j] = ready_q[s1_tag[j]] | wb_hit(wb_valid, wb_tag, s1_tag[j]);
      end
      if (rs2_idx_l[j] == '0) begin
        s2_rdy[j] = 1'b1;
      end else if (s2_byp[j]) begin
        s2_rdy[j] = 1'b0;
      end else begin
        s2_rdy[j] = ready_q[s2_tag[j]] | wb_hit(wb_valid, wb_tag, s2_tag[j]);
      end
    end
  end

  // Next-state computation for map, ready bits and checkpoint bookkeeping.
  always_comb begin
    map_ren = map_q;
    for (int j = 0; j < int'(RN_WIDTH); j++) begin
      if (lane_wr[j]) map_ren[rd_idx_l[j]] = new_tag_l[j];
    end
    map_d = ckpt_restore ? ckpt_q[ckpt_restore_id] : map_ren;

    // Set from writeback first so that a same-tag allocation clears it.
    ready_d = ready_q;
    for (int w = 0; w < int'(NUM_WB); w++) begin
      if (wb_valid[w]) ready_d[wb_tag_l[w]] = 1'b1;
    end
    if (!ckpt_restore) begin
      for (int j = 0; j < int'(RN_WIDTH); j++) begin
        if (lane_wr[j]) ready_d[new_tag_l[j]] = 1'b0;
      end
    end

    save_en = ckpt_save & ~ckpt_full_q & ~ckpt_restore;

    busy_d = busy_q;
    if (ckpt_restore) busy_d = busy_d & ~ckpt_kill_mask;
    if (ckpt_release) busy_d[ckpt_release_id] = 1'b0;
    if (save_en)      busy_d[ckpt_id_q] = 1'b1;

    ckpt_full_d = &busy_d;
    ckpt_id_d   = '0;
    for (int i = int'(NUM_CKPT) - 1; i >= 0; i--) begin
      if (!busy_d[i]) ckpt_id_d = CKPT_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_AREG); i++) begin
        map_q[i] <= PREG_WIDTH'(i);
      end
      ready_q     <= '1;
      busy_q      <= '0;
      ckpt_id_q   <= '0;
      ckpt_full_q <= 1'b0;
    end else begin
      map_q       <= map_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      ckpt_id_q   <= ckpt_id_d;
      ckpt_full_q <= ckpt_full_d;
    end
  end

  // Snapshot storage needs no reset: a slot is only read after a save marks it busy.
  always_ff @(posedge clk) begin
    if (rst && save_en) ckpt_q[ckpt_id_q] <= map_ren;
  end

  assign ckpt_id   = ckpt_id_q;
  assign ckpt_full = ckpt_full_q;

endmodule

// File: tb/tb_rename_map_table.sv
module tb_rename_map_table;

  logic        clk;
  logic        rst;
  logic [1:0]  rn_valid;
  logic [9:0]  rn_rs1_idx, rn_rs2_idx, rn_rd_idx;
  logic [1:0]  rn_rd_write;
  logic [11:0] rn_rd_tag;
  logic [11:0] rs1_tag, rs2_tag, rd_old_tag;
  logic [1:0]  rs1_ready, rs2_ready;
  logic [1:0]  wb_valid;
  logic [11:0] wb_tag;
  logic        ckpt_save;
  logic [1:0]  ckpt_id;
  logic        ckpt_full;
  logic        ckpt_restore;
  logic [1:0]  ckpt_restore_id;
  logic [3:0]  ckpt_kill_mask;
  logic        ckpt_release;
  logic [1:0]  ckpt_release_id;

  int checks = 0;
  int errors = 0;

  rename_map_table dut (
    .clk            (clk),
    .rst            (rst),
    .rn_valid       (rn_valid),
    .rn_rs1_idx     (rn_rs1_idx),
    .rn_rs2_idx     (rn_rs2_idx),
    .rn_rd_idx      (rn_rd_idx),
    .rn_rd_write    (rn_rd_write),
    .rn_rd_tag      (rn_rd_tag),
    .rs1_tag        (rs1_tag),
    .rs2_tag        (rs2_tag),
    .rs1_ready      (rs1_ready),
    .rs2_ready      (rs2_ready),
    .rd_old_tag     (rd_old_tag),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .ckpt_save      (ckpt_save),
    .ckpt_id        (ckpt_id),
    .ckpt_full      (ckpt_full),
    .ckpt_restore   (ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id),
    .ckpt_kill_mask (ckpt_kill_mask),
    .ckpt_release   (ckpt_release),
    .ckpt_release_id(ckpt_release_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b1;
    rn_valid = '0; rn_rs1_idx = '0; rn_rs2_idx = '0; rn_rd_idx = '0;
    rn_rd_write = '0; rn_rd_tag = '0;
    wb_valid = '0; wb_tag = '0;
    ckpt_save = 1'b0; ckpt_restore = 1'b0; ckpt_restore_id = '0; ckpt_kill_mask = '0;
    ckpt_release = 1'b0; ckpt_release_id = '0;
  endtask

  task automatic ln(input int j, input logic [4:0] s1, input logic [4:0] s2,
                    input logic [4:0] rd, input logic wr, input logic [5:0] tag);
    rn_valid[j] = 1'b1;
    rn_rs1_idx[j*5 +: 5] = s1;
    rn_rs2_idx[j*5 +: 5] = s2;
    rn_rd_idx[j*5 +: 5]  = rd;
    rn_rd_write[j]       = wr;
    rn_rd_tag[j*6 +: 6]  = tag;
  endtask

  // Start of a cycle: inputs cleared at the falling edge.
  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state: identity map, all ready, no checkpoints.
    for (int i = 0; i < 32; i++) begin
      cyc();
      ln(0, 5'(i), 5'd0, 5'd0, 1'b0, 6'd0);
      ln(1, 5'd0, 5'(i), 5'd0, 1'b0, 6'd0);
      #1;
      chk("reset_rs1_tag", 32'(rs1_tag[5:0]), 32'(i));
      chk("reset_rs1_rdy", 32'(rs1_ready[0]), 32'd1);
      chk("reset_rs2_tag", 32'(rs2_tag[11:6]), 32'(i));
      chk("reset_rs2_rdy", 32'(rs2_ready[1]), 32'd1);
    end
    chk("reset_ckpt_full", 32'(ckpt_full), 32'd0);
    chk("reset_ckpt_id", 32'(ckpt_id), 32'd0);

    // Intra-group bypass and youngest-lane-wins on the same rd.
    cyc();
    ln(0, 5'd5, 5'd0, 5'd5, 1'b1, 6'd40);
    ln(1, 5'd5, 5'd5, 5'd5, 1'b1, 6'd41);
    #1;
    chk("l0_rs1_tag", 32'(rs1_tag[5:0]), 32'd5);
    chk("l0_rs1_rdy", 32'(rs1_ready[0]), 32'd1);
    chk("l0_rd_old", 32'(rd_old_tag[5:0]), 32'd5);
    chk("byp_rs1_tag", 32'(rs1_tag[11:6]), 32'd40);
    chk("byp_rs1_rdy", 32'(rs1_ready[1]), 32'd0);
    chk("byp_rs2_tag", 32'(rs2_tag[11:6]), 32'd40);
    chk("byp_rs2_rdy", 32'(rs2_ready[1]), 32'd0);
    chk("byp_rd_old", 32'(rd_old_tag[11:6]), 32'd40);
    cyc();
    ln(0, 5'd5, 5'd0, 5'd0, 1'b0, 6'd0);
    #1;
    chk("map5_after", 32'(rs1_tag[5:0]), 32'd41);
    chk("map5_rdy_after", 32'(rs1_ready[0]), 32'd0);

    // Same-cycle writeback wakeup.
    ln(0, 5'd5, 5'd0, 5'd3, 1'b1, 6'd50);
    cyc();
    ln(0, 5'd3, 5'd0, 5'd0, 1'b0, 6'd0);
    ln(1, 5'd3, 5'd0, 5'd0, 1'b0, 6'd0);
    wb_valid = 2'b10;
    wb_tag = {6'd50, 6'd0};
    #1;
    chk("wb_bypass_tag", 32'(rs1_tag[5:0]), 32'd50);
    chk("wb_bypass_rdy0", 32'(rs1_ready[0]), 32'd1);
    chk("wb_bypass_rdy1", 32'(rs1_ready[1]), 32'd1);
    cyc();
    ln(0, 5'd3, 5'd0, 5'd0, 1'b0, 6'd0);
    #1;
    chk("wb_ready_latched", 32'(rs1_ready[0]), 32'd1);

    // Allocation beats writeback on the same tag; x0 is never renamed.
    cyc();
    ln(0, 5'd0, 5'd0, 5'd9, 1'b1, 6'd33);
    ln(1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd62);
    wb_valid = 2'b01;
    wb_tag = {6'd0, 6'd33};
    #1;
    chk("x0_rd_old", 32'(rd_old_tag[11:6]), 32'd0);
    chk("x0_rs2_tag", 32'(rs2_tag[11:6]), 32'd0);
    chk("x0_rs2_rdy", 32'(rs2_ready[1]), 32'd1);
    cyc();
    ln(0, 5'd9, 5'd0, 5'd0, 1'b0, 6'd0);
    ln(1, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
    #1;
    chk("clr_wins_tag", 32'(rs1_tag[5:0]), 32'd33);
    chk("clr_wins_rdy", 32'(rs1_ready[0]), 32'd0);
    chk("x0_map_kept", 32'(rs1_tag[11:6]), 32'd0);

    // Save includes this cycle's rename; restore undoes later renames.
    cyc();
    ckpt_save = 1'b1;
    ln(0, 5'd0, 5'd0, 5'd8, 1'b1, 6'd44);
    cyc();
    #1;
    chk("save_ckpt_id", 32'(ckpt_id), 32'd1);
    chk("save_ckpt_full", 32'(ckpt_full), 32'd0);
    ln(0, 5'd0, 5'd0, 5'd7, 1'b1, 6'd60);
    cyc();
    ln(0, 5'd7, 5'd0, 5'd0, 1'b0, 6'd0);
    #1;
    chk("pre_restore_map7", 32'(rs1_tag[5:0]), 32'd60);
    ln(1, 5'd0, 5'd0, 5'd7, 1'b1, 6'd61);
    ckpt_save = 1'b1;
    ckpt_restore = 1'b1;
    ckpt_restore_id = 2'd0;
    ckpt_kill_mask = 4'b0001;
    cyc();
    ln(0, 5'd7, 5'd8, 5'd0, 1'b0, 6'd0);
    ln(1, 5'd5, 5'd0, 5'd0, 1'b0, 6'd0);
    #1;
    chk("restore_map7", 32'(rs1_tag[5:0]), 32'd7);
    chk("restore_map7_rdy", 32'(rs1_ready[0]), 32'd1);
    chk("restore_map8", 32'(rs2_tag[5:0]), 32'd44);
    chk("restore_rdy_kept", 32'(rs2_ready[0]), 32'd0);
    chk("restore_map5", 32'(rs1_tag[11:6]), 32'd41);
    chk("restore_ckpt_id", 32'(ckpt_id), 32'd0);
    chk("restore_ckpt_full", 32'(ckpt_full), 32'd0);

    // Fill all slots, ignored save when full, release and restore together.
    cyc(); ckpt_save = 1'b1;
    cyc(); #1; chk("fill_id1", 32'(ckpt_id), 32'd1); ckpt_save = 1'b1;
    cyc(); #1; chk("fill_id2", 32'(ckpt_id), 32'd2); ckpt_save = 1'b1;
    cyc(); #1; chk("fill_id3", 32'(ckpt_id), 32'd3);
    chk("fill_not_full", 32'(ckpt_full), 32'd0); ckpt_save = 1'b1;
    cyc(); #1; chk("fill_full", 32'(ckpt_full), 32'd1);
    ckpt_save = 1'b1;
    ln(0, 5'd0, 5'd0, 5'd10, 1'b1, 6'd20);
    cyc();
    ln(0, 5'd10, 5'd0, 5'd0, 1'b0, 6'd0);
    #1;
    chk("full_save_ignored", 32'(ckpt_full), 32'd1);
    chk("full_rename_applied", 32'(rs1_tag[5:0]), 32'd20);
    ckpt_release = 1'b1;
    ckpt_release_id = 2'd2;
    cyc(); #1;
    chk("release_id", 32'(ckpt_id), 32'd2);
    chk("release_not_full", 32'(ckpt_full), 32'd0);
    ckpt_release = 1'b1;
    ckpt_release_id = 2'd2;
    cyc(); #1;
    chk("release_free_noop_id", 32'(ckpt_id), 32'd2);
    chk("release_free_noop_full", 32'(ckpt_full), 32'd0);
    ckpt_restore = 1'b1;
    ckpt_restore_id = 2'd3;
    ckpt_kill_mask = 4'b1000;
    ckpt_release = 1'b1;
    ckpt_release_id = 2'd1;
    cyc();
    ln(0, 5'd10, 5'd5, 5'd0, 1'b0, 6'd0);
    #1;
    chk("rel_rst_id", 32'(ckpt_id), 32'd1);
    chk("rel_rst_full", 32'(ckpt_full), 32'd0);
    chk("rel_rst_map10", 32'(rs1_tag[5:0]), 32'd10);
    chk("rel_rst_map5", 32'(rs2_tag[5:0]), 32'd41);

    // Reset in the middle of a rename and a restore.
    cyc();
    rst = 1'b0;
    ln(0, 5'd0, 5'd0, 5'd5, 1'b1, 6'd30);
    ckpt_restore = 1'b1;
    ckpt_restore_id = 2'd0;
    ckpt_kill_mask = 4'b0001;
    cyc();
    ln(0, 5'd5, 5'd8, 5'd0, 1'b0, 6'd0);
    ln(1, 5'd3, 5'd9, 5'd0, 1'b0, 6'd0);
    #1;
    chk("rst2_map5", 32'(rs1_tag[5:0]), 32'd5);
    chk("rst2_map5_rdy", 32'(rs1_ready[0]), 32'd1);
    chk("rst2_map8", 32'(rs2_tag[5:0]), 32'd8);
    chk("rst2_map3", 32'(rs1_tag[11:6]), 32'd3);
    chk("rst2_map9", 32'(rs2_tag[11:6]), 32'd9);
    chk("rst2_map9_rdy", 32'(rs2_ready[1]), 32'd1);
    chk("rst2_ckpt_id", 32'(ckpt_id), 32'd0);
    chk("rst2_ckpt_full", 32'(ckpt_full), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
